// File: rtl/serial_addcmp_if.sv
// Handshake and result bundle for the bit-serial add/subtract/compare unit.
// The master side issues operations; the slave side is the datapath.
interface serial_addcmp_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             op_sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             a_gt_b;
   logic             a_eq_b;
   logic             a_lt_b;

   modport master (
      output start, op_sub, a, b,
      input  busy, done, result, cout, a_gt_b, a_eq_b, a_lt_b
   );

   modport slave (
      input  start, op_sub, a, b,
      output busy, done, result, cout, a_gt_b, a_eq_b, a_lt_b
   );
endinterface

// File: rtl/serial_addcmp.sv
// Bit-serial adder/subtractor with unsigned magnitude compare.
// Operands are captured on an accepted start and consumed LSB first, one bit
// per clock. Sum bits enter a shadow register from the MSB side; the shadow
// and the compare flags are copied to the visible outputs only when the last
// bit is processed, so the outputs stay stable for the whole run.
module serial_addcmp #(
   parameter  int WIDTH = 4,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic            clk,
   input  logic            rst,
   serial_addcmp_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Full-adder carry: majority of the three inputs.
   function automatic logic maj3(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

   state_t           state_r;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;      // b, or ~b when subtracting
   logic [WIDTH-1:0] sum_sh_r;
   logic [CNT_W-1:0] cnt_r;
   logic             carry_r;
   logic             sub_r;
   logic             gt_r;
   logic             eq_r;

   logic             a_bit_s;
   logic             bp_bit_s;
   logic             b_bit_s;
   logic             sum_bit_s;
   logic             carry_nxt_s;
   logic             gt_nxt_s;
   logic             eq_nxt_s;
   logic             last_s;
   logic [WIDTH-1:0] sum_nxt_s;

   // Per-bit datapath: one full-adder step plus one compare step on bit 0.
   always_comb begin
      a_bit_s     = a_sh_r[0];
      bp_bit_s    = b_sh_r[0];
      // Compare must see the original b bit, so undo the subtract inversion.
      b_bit_s     = bp_bit_s ^ sub_r;
      sum_bit_s   = a_bit_s ^ bp_bit_s ^ carry_r;
      carry_nxt_s = maj3(a_bit_s, bp_bit_s, carry_r);
      sum_nxt_s   = {sum_bit_s, sum_sh_r[WIDTH-1:1]};
      last_s      = (cnt_r == CNT_W'(WIDTH - 1));
      // A differing bit decides the order; later (higher) bits overwrite it.
      if (a_bit_s != b_bit_s) begin
         gt_nxt_s = a_bit_s;
         eq_nxt_s = 1'b0;
      end else begin
         gt_nxt_s = gt_r;
         eq_nxt_s = eq_r;
      end
   end

   // Control FSM, operand shifting and registered result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         a_sh_r     <= {WIDTH{1'b0}};
         b_sh_r     <= {WIDTH{1'b0}};
         sum_sh_r   <= {WIDTH{1'b0}};
         cnt_r      <= {CNT_W{1'b0}};
         carry_r    <= 1'b0;
         sub_r      <= 1'b0;
         gt_r       <= 1'b0;
         eq_r       <= 1'b1;
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
         bus.result <= {WIDTH{1'b0}};
         bus.cout   <= 1'b0;
         bus.a_gt_b <= 1'b0;
         bus.a_eq_b <= 1'b0;
         bus.a_lt_b <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state_r)
            IDLE, DONE: begin
               // DONE accepts a new start too, giving back-to-back operation.
               if (bus.start) begin
                  a_sh_r   <= bus.a;
                  b_sh_r   <= bus.op_sub ? ~bus.b : bus.b;
                  carry_r  <= bus.op_sub;
                  sub_r    <= bus.op_sub;
                  sum_sh_r <= {WIDTH{1'b0}};
                  cnt_r    <= {CNT_W{1'b0}};
                  gt_r     <= 1'b0;
                  eq_r     <= 1'b1;
                  bus.busy <= 1'b1;
                  state_r  <= RUN;
               end else begin
                  bus.busy <= 1'b0;
                  state_r  <= IDLE;
               end
            end
            RUN: begin
               a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
               b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
               sum_sh_r <= sum_nxt_s;
               carry_r  <= carry_nxt_s;
               gt_r     <= gt_nxt_s;
               eq_r     <= eq_nxt_s;
               if (last_s) begin
                  bus.busy   <= 1'b0;
                  bus.done   <= 1'b1;
                  bus.result <= sum_nxt_s;
                  bus.cout   <= carry_nxt_s;
                  bus.a_gt_b <= gt_nxt_s;
                  bus.a_eq_b <= eq_nxt_s;
                  bus.a_lt_b <= ~gt_nxt_s & ~eq_nxt_s;
                  state_r    <= DONE;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            default: begin
               bus.busy <= 1'b0;
               state_r  <= IDLE;
            end
         endcase
      end
   end

endmodule
